// File: rtl/systolic_sequencer.sv
// Batch sequencer for a weight-stationary NxN PE matrix: loads the weight tile, skews
// activations into the left edge, deskews bottom-edge sums. Optional SEQ_PERF_EN adds perf counters.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting N weight rows into the tile
// STREAM | feeding activation vectors (bubbles when none offered)
// DRAIN  | waiting for the last tagged result to leave
// DONE   | one-cycle completion pulse
module systolic_sequencer #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vec,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    input  logic [N*WIDTH-1:0]     w_row,
    output logic                   w_ready,
    input  logic                   act_valid,
    input  logic [N*WIDTH-1:0]     act_data,
    output logic                   act_ready,
    output logic [N*N*WIDTH-1:0]   arr_weights,
    output logic [N*WIDTH-1:0]     arr_in_left,
    output logic [N*WIDTH-1:0]     arr_in_up,
    output logic [N-1:0]           arr_enable,
    input  logic [N*WIDTH-1:0]     arr_out_down,
    output logic                   res_valid,
    output logic [N*WIDTH-1:0]     res_data
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls
`endif
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [ROW_W-1:0]     row_cnt;
    logic [CNT_W-1:0]     vec_left;
    logic [2*N-1:0]       tag_pipe;
    logic                 accept;
    logic [N*WIDTH-1:0]   feed;
    logic [N*WIDTH-1:0]   deskew_out;

    assign accept    = act_valid && act_ready;
    assign feed      = accept ? act_data : '0;
    assign arr_in_up = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        w_ready    = 1'b0;
        act_ready  = 1'b0;
        arr_enable = '0;
        case (state)
            IDLE: if (start) state_nxt = LOAD_W;
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && row_cnt == ROW_W'(N-1))
                    state_nxt = (vec_left == '0) ? DONE : STREAM;
            end
            STREAM: begin
                act_ready  = (vec_left != '0);
                arr_enable = '1;
                if (accept && vec_left == CNT_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                arr_enable = '1;
                if (tag_pipe == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt     <= '0;
            vec_left    <= '0;
            arr_weights <= '0;
        end else begin
            if (state == IDLE && start) begin
                vec_left <= num_vec;
                row_cnt  <= '0;
            end
            if (state == LOAD_W && w_valid) begin
                for (int r = 0; r < N; r++)
                    if (row_cnt == ROW_W'(r)) arr_weights[r*N*WIDTH +: N*WIDTH] <= w_row;
                row_cnt <= row_cnt + 1'b1;
            end
            if (accept) vec_left <= vec_left - 1'b1;
        end
    end

    // Row i is delayed i+1 cycles so the wavefront enters the matrix diagonally.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] chain [i+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++) chain[k] <= '0;
            end else begin
                chain[0] <= feed[i*WIDTH +: WIDTH];
                for (int k = 1; k <= i; k++) chain[k] <= chain[k-1];
            end
        end
        assign arr_in_left[i*WIDTH +: WIDTH] = chain[i];
    end

    // Column j leaves the matrix j cycles after column 0; pad it back into alignment.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign deskew_out[j*WIDTH +: WIDTH] = arr_out_down[j*WIDTH +: WIDTH];
        end else begin : g_dly
            logic [WIDTH-1:0] dly [D];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) dly[k] <= '0;
                end else begin
                    dly[0] <= arr_out_down[j*WIDTH +: WIDTH];
                    for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
                end
            end
            assign deskew_out[j*WIDTH +: WIDTH] = dly[D-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_pipe  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            tag_pipe  <= {tag_pipe[2*N-2:0], accept};
            res_valid <= tag_pipe[2*N-1];
            if (tag_pipe[2*N-1]) res_data <= deskew_out;
        end
    end

`ifdef SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (state != IDLE && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (state == STREAM && !act_valid && perf_stalls != '1)
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural PE matrix on the array ports, matrix-vector
// scoreboard with fixed result latency, directed and randomized batches.
module tb_systolic_sequencer;
    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int LAT   = 2*N + 1;

    logic                 clk, rst, start, busy, done;
    logic [CNT_W-1:0]     num_vec;
    logic                 w_valid, w_ready, act_valid, act_ready, res_valid;
    logic [N*WIDTH-1:0]   w_row, act_data, arr_in_left, arr_in_up, arr_out_down, res_data;
    logic [N*N*WIDTH-1:0] arr_weights;
    logic [N-1:0]         arr_enable;
`ifdef SEQ_PERF_EN
    logic [31:0]          perf_cycles, perf_stalls;
`endif

    systolic_sequencer #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .w_valid(w_valid), .w_row(w_row), .w_ready(w_ready),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .arr_weights(arr_weights), .arr_in_left(arr_in_left), .arr_in_up(arr_in_up),
        .arr_enable(arr_enable), .arr_out_down(arr_out_down),
        .res_valid(res_valid), .res_data(res_data)
`ifdef SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural weight-stationary matrix: one register stage per PE for both paths.
    logic signed [WIDTH-1:0] pe_a [N][N];
    logic signed [WIDTH-1:0] pe_p [N][N];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    pe_a[r][c] <= '0;
                    pe_p[r][c] <= '0;
                end
        end else begin
            for (int c = 0; c < N; c++)
                if (arr_enable[c])
                    for (int r = 0; r < N; r++) begin
                        logic signed [WIDTH-1:0] a_in, p_in, wv;
                        if (c == 0) a_in = $signed(arr_in_left[r*WIDTH +: WIDTH]);
                        else        a_in = pe_a[r][c-1];
                        if (r == 0) p_in = $signed(arr_in_up[c*WIDTH +: WIDTH]);
                        else        p_in = pe_p[r-1][c];
                        wv = $signed(arr_weights[(r*N+c)*WIDTH +: WIDTH]);
                        pe_a[r][c] <= a_in;
                        pe_p[r][c] <= p_in + a_in * wv;
                    end
        end
    end
    always_comb begin
        arr_out_down = '0;
        for (int c = 0; c < N; c++) arr_out_down[c*WIDTH +: WIDTH] = pe_p[N-1][c];
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    int exp_w [N][N];

    function automatic logic [N*WIDTH-1:0] pack4(int a0, int a1, int a2, int a3);
        return {WIDTH'(a3), WIDTH'(a2), WIDTH'(a1), WIDTH'(a0)};
    endfunction

    function automatic logic [N*WIDTH-1:0] pack_row(int r);
        logic [N*WIDTH-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*WIDTH +: WIDTH] = WIDTH'(exp_w[r][c]);
        return v;
    endfunction

    function automatic logic [N*WIDTH-1:0] ref_mv(logic [N*WIDTH-1:0] act);
        logic [N*WIDTH-1:0] v;
        int s;
        v = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += int'($signed(act[i*WIDTH +: WIDTH])) * exp_w[i][j];
            v[j*WIDTH +: WIDTH] = WIDTH'(s);
        end
        return v;
    endfunction

    typedef struct {
        int                 due;
        logic [N*WIDTH-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_new;
    int   done_cnt = 0, res_cnt = 0, done_cyc = 0, last_res_cyc = 0;
    bit   en_seen = 1'b0;

    // Scoreboard: each accepted vector owes exactly one result LAT cycles later.
    always @(negedge clk) begin
        if (rst) begin
            if (|arr_enable) en_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (act_valid && act_ready) begin
                e_new.due  = cyc + LAT;
                e_new.data = ref_mv(act_data);
                exp_q.push_back(e_new);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("res_valid", res_valid, 1);
                if (res_valid) begin
                    check("res_data", res_data, exp_q[0].data);
                    res_cnt++;
                    last_res_cyc = cyc;
                end
                void'(exp_q.pop_front());
            end else if (res_valid) begin
                check("res_spurious", res_valid, 0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int nv);
        start   = 1'b1;
        num_vec = CNT_W'(nv);
        tick();
        start   = 1'b0;
    endtask

    task automatic load_w(input bit rnd_stall);
        for (int r = 0; r < N; r++) begin
            int k = 0;
            w_valid = 1'b0;
            if (rnd_stall) tick($urandom_range(0, 2));
            w_valid = 1'b1;
            w_row   = pack_row(r);
            @(negedge clk);
            while (!w_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!w_ready) check("w_ready_timeout", w_ready, 1);
            tick();
        end
        w_valid = 1'b0;
        w_row   = '0;
    endtask

    task automatic send_vec(input logic [N*WIDTH-1:0] v, input int gap);
        int k = 0;
        act_valid = 1'b0;
        tick(gap);
        act_valid = 1'b1;
        act_data  = v;
        @(negedge clk);
        while (!act_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!act_ready) check("act_ready_timeout", act_ready, 1);
        tick();
        act_valid = 1'b0;
        act_data  = '0;
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        tick(2);
    endtask

    logic [N*WIDTH-1:0] vecs[$];
    int                 gaps[$];

    task automatic run_batch(input bit rnd_stall);
        int r0, d0, nv;
        nv = vecs.size();
        r0 = res_cnt;
        d0 = done_cnt;
        do_start(nv);
        load_w(rnd_stall);
        for (int i = 0; i < nv; i++) send_vec(vecs[i], gaps[i]);
        wait_done();
        check("res_count", res_cnt - r0, nv);
        check("done_once", done_cnt - d0, 1);
        if (nv > 0) check("done_after_res", done_cyc > last_res_cyc, 1);
        check("busy_idle", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        for (int r = 0; r < N; r++)
            check("tile_hold", arr_weights[r*N*WIDTH +: N*WIDTH], pack_row(r));
    endtask

    task automatic set_w_ones();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) exp_w[r][c] = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        rst = 1'b0; start = 1'b0; num_vec = '0; w_valid = 1'b0; w_row = '0;
        act_valid = 1'b0; act_data = '0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_act_ready", act_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_enable", arr_enable, 0);
        check("rst_weights", |arr_weights, 0);
        check("rst_in_left", arr_in_left, 0);
        check("rst_res_data", res_data, 0);
        check("rst_in_up", arr_in_up, 0);
        rst = 1'b1;
        tick(2);

        // identity weights, single vector
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) exp_w[r][c] = (r == c) ? 1 : 0;
        vecs = '{pack4(1, 2, 3, 4)};
        gaps = '{0};
        run_batch(1'b0);
        check("ident_res", res_data, pack4(1, 2, 3, 4));

        // all-ones weights, back-to-back vectors
        set_w_ones();
        vecs = '{pack4(1, 1, 1, 1), pack4(2, 0, 0, 0), pack4(-1, -1, -1, -1)};
        gaps = '{0, 0, 0};
        run_batch(1'b0);
        check("ones_last", res_data, pack4(-4, -4, -4, -4));

        // two-cycle bubble between vectors 1 and 2
        gaps = '{0, 2, 0};
        run_batch(1'b0);
`ifdef SEQ_PERF_EN
        check("perf_stalls", perf_stalls, 2);
`endif

        // empty batch
        en_seen = 1'b0;
        vecs.delete();
        gaps.delete();
        run_batch(1'b0);
        check("empty_no_enable", en_seen, 0);

        // reset three cycles into STREAM
        do_start(5);
        load_w(1'b0);
        send_vec(pack4(5, 6, 7, 8), 0);
        send_vec(pack4(1, 2, 3, 4), 0);
        send_vec(pack4(9, 9, 9, 9), 0);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_act_ready", act_ready, 0);
        check("mid_rst_enable", arr_enable, 0);
        check("mid_rst_in_left", arr_in_left, 0);
        check("mid_rst_weights", |arr_weights, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_done", done, 0);
        r0 = res_cnt;
        d0 = done_cnt;
        tick(3);
        rst = 1'b1;
        tick(15);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_res", res_cnt - r0, 0);
        vecs = '{pack4(3, -2, 7, 1), pack4(0, 4, -5, 2)};
        gaps = '{0, 1};
        run_batch(1'b0);

        // start while busy is ignored
        set_w_ones();
        r0 = res_cnt;
        do_start(2);
        start = 1'b1;
        num_vec = CNT_W'(7);
        load_w(1'b0);
        send_vec(pack4(1, 2, 3, 4), 0);
        send_vec(pack4(2, 2, 2, 2), 1);
        start = 1'b0;
        wait_done();
        check("busy_start_count", res_cnt - r0, 2);
        check("busy_start_idle", busy, 0);

        // randomized batches
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    exp_w[r][c] = int'($signed(16'($urandom)));
            vecs.delete();
            gaps.delete();
            for (int v = 0; v < int'($urandom_range(1, 6)); v++) begin
                vecs.push_back({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
                gaps.push_back(int'($urandom_range(0, 2)));
            end
            run_batch(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
